// File: rtl/buffer_pkg.sv
// Shared types and default geometry for the segmented packet buffer (write and read sides).
package buffer_pkg;

  localparam int DEF_BUF_SEG_AW     = 10;
  localparam int DEF_SEGMENT_SIZE_W = 10;

  typedef logic [DEF_BUF_SEG_AW-1:0] seg_ptr_t;

  typedef struct packed {
    logic     eop;
    seg_ptr_t seg;
  } used_ptr_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ptr_cache_state_t;

endpackage

// File: rtl/buffer_ptr_prefetch.sv
// Two-entry segment pointer cache in front of the show-ahead free list.
// cur is the segment being filled; nxt is prefetched so a segment can close
// and the next beat can land in a fresh segment without a bubble.
module buffer_ptr_prefetch
  import buffer_pkg::*;
#(
  parameter int SEG_AW = DEF_BUF_SEG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEG_AW-1:0] f_ptr,
  input  logic              f_ptr_valid,
  output logic              f_ptr_pop,
  input  logic              close,
  output logic [SEG_AW-1:0] cur,
  output logic              cur_valid
);

  ptr_cache_state_t  r_state;
  logic [SEG_AW-1:0] r_cur;
  logic [SEG_AW-1:0] r_nxt;
  logic              w_pop;

  // Pop whenever there is a free slot; the head is captured on the same edge.
  assign w_pop     = f_ptr_valid && (r_state != TWO);
  assign f_ptr_pop = w_pop;
  assign cur       = r_cur;
  assign cur_valid = (r_state != EMPTY);

  // Cache fill and advance; a close with a simultaneous pop refills the vacated slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_cur   <= '0;
      r_nxt   <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_pop) begin
            r_cur   <= f_ptr;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (close && w_pop) begin
            r_cur <= f_ptr;
          end else if (close) begin
            r_state <= EMPTY;
          end else if (w_pop) begin
            r_nxt   <= f_ptr;
            r_state <= TWO;
          end
        end
        TWO: begin
          if (close) begin
            r_cur   <= r_nxt;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/buffer_write.sv
// Write side of the segmented packet buffer: places stream beats at {segment, offset}
// and publishes each closed segment, tagged with end-of-packet, to the read side.
module buffer_write
  import buffer_pkg::*;
#(
  parameter int SEGMENT_SIZE_W = DEF_SEGMENT_SIZE_W,
  parameter int BUF_SEG_AW     = DEF_BUF_SEG_AW,
  parameter int ADDR_WIDTH     = BUF_SEG_AW + SEGMENT_SIZE_W,
  parameter int DATA_WIDTH     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  input  logic [BUF_SEG_AW-1:0] f_ptr,
  input  logic                  f_ptr_valid,
  output logic                  f_ptr_pop,
  output logic                  b_wen,
  output logic [ADDR_WIDTH-1:0] b_waddr,
  output logic [DATA_WIDTH-1:0] b_wdata,
  output logic [BUF_SEG_AW:0]   used_pointer,
  output logic                  used_pointer_valid
);

  localparam logic [SEGMENT_SIZE_W-1:0] OFFSET_LAST = '1;

  logic [BUF_SEG_AW-1:0]     w_cur;
  logic                      w_cur_valid;
  logic                      w_accept;
  logic                      w_close;
  logic [SEGMENT_SIZE_W-1:0] r_offset;
  logic                      r_wen;
  logic [ADDR_WIDTH-1:0]     r_waddr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic                      r_close_d;
  logic [BUF_SEG_AW:0]       r_close_ptr;
  logic                      r_up_valid;
  logic [BUF_SEG_AW:0]       r_up;

  buffer_ptr_prefetch #(
    .SEG_AW (BUF_SEG_AW)
  ) u_prefetch (
    .clk         (clk),
    .rst         (rst),
    .f_ptr       (f_ptr),
    .f_ptr_valid (f_ptr_valid),
    .f_ptr_pop   (f_ptr_pop),
    .close       (w_close),
    .cur         (w_cur),
    .cur_valid   (w_cur_valid)
  );

  // Ready depends only on holding a segment, so it never waits on s_tvalid.
  assign s_tready = w_cur_valid;
  assign w_accept = s_tvalid && w_cur_valid;
  // A packet end or a full segment both retire the current segment.
  assign w_close  = w_accept && (s_tlast || (r_offset == OFFSET_LAST));

  assign b_wen              = r_wen;
  assign b_waddr            = r_waddr;
  assign b_wdata            = r_wdata;
  assign used_pointer       = r_up;
  assign used_pointer_valid = r_up_valid;

  // Beat offset within the current segment; restarts at 0 for every new segment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_offset <= '0;
    end else if (w_close) begin
      r_offset <= '0;
    end else if (w_accept) begin
      r_offset <= r_offset + 1'b1;
    end
  end

  // Registered RAM write port, one cycle behind the accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_accept;
      if (w_accept) begin
        r_waddr <= {w_cur, r_offset};
        r_wdata <= s_tdata;
      end
    end
  end

  // Publish the closed segment one cycle after its last write so the data is in RAM first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_close_d   <= 1'b0;
      r_close_ptr <= '0;
      r_up_valid  <= 1'b0;
      r_up        <= '0;
    end else begin
      r_close_d  <= w_close;
      r_up_valid <= r_close_d;
      if (w_close) begin
        r_close_ptr <= {s_tlast, w_cur};
      end
      if (r_close_d) begin
        r_up <= r_close_ptr;
      end
    end
  end

  // Handshake sanity: pops only from a non-empty list, beats only into a held segment,
  // and a full segment is always closed instead of wrapping its offset.
  a_pop_valid : assert property (@(posedge clk) disable iff (rst) f_ptr_pop |-> f_ptr_valid);
  a_accept_seg : assert property (@(posedge clk) disable iff (rst) (s_tvalid && s_tready) |-> w_cur_valid);
  a_offset_wrap : assert property (@(posedge clk) disable iff (rst)
                                   (w_accept && (r_offset == OFFSET_LAST)) |-> w_close);

endmodule
